// File: rtl/djb2_rewind.sv
// Rewinds a DJB2 hash byte-by-byte (bytes presented last-to-first) and reports whether INIT is recovered.
// One byte per cycle while in RUN; done/match/error are a one-cycle pulse in DONE.
module djb2_rewind #(
    parameter logic [31:0] INIT   = 32'd5381,
    parameter logic [15:0] MAXLEN = 16'd255
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] target,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] state,
    output logic [15:0] count,
    output logic        done,
    output logic        match,
    output logic        error
);

    // Multiplicative inverse of 33 modulo 2^32
    localparam logic [31:0] INV33 = 32'h3E0F83E1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [31:0] state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;
    logic        accept;
    logic [31:0] rewound;

    assign accept  = in_valid && (fsm_q == S_RUN);
    assign rewound = (state_q ^ {24'b0, in_data}) * INV33;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fsm_q   <= S_IDLE;
            state_q <= INIT;
            count_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    state_d = target;
                    count_d = 16'd0;
                    fsm_d   = S_RUN;
                end
            end
            S_RUN: begin
                // start wins over a byte offered in the same cycle
                if (start) begin
                    state_d = target;
                    count_d = 16'd0;
                end else if (accept) begin
                    if (count_q == MAXLEN) begin
                        fsm_d = S_DONE;
                        err_d = 1'b1;
                    end else begin
                        state_d = rewound;
                        count_d = count_q + 16'd1;
                        if (in_last) begin
                            fsm_d = S_DONE;
                            err_d = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = target;
                    count_d = 16'd0;
                    fsm_d   = S_RUN;
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign in_ready = (fsm_q == S_RUN);
    assign done     = (fsm_q == S_DONE);
    // An overflowed job never reports a match, even if state happens to equal INIT
    assign match    = done && !err_q && (state_q == INIT);
    assign error    = done && err_q;
    assign state    = state_q;
    assign count    = count_q;

endmodule

// File: tb/tb_djb2_rewind.sv
// Directed bench for djb2_rewind: default instance plus a MAXLEN=2 instance sharing the same stimulus.
module tb_djb2_rewind;

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] target;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;

    logic        rdy_a, done_a, match_a, error_a;
    logic [31:0] state_a;
    logic [15:0] count_a;
    logic        rdy_b, done_b, match_b, error_b;
    logic [31:0] state_b;
    logic [15:0] count_b;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    djb2_rewind dut_a (
        .clock(clock), .resetn(resetn), .start(start), .target(target),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy_a), .state(state_a), .count(count_a),
        .done(done_a), .match(match_a), .error(error_a)
    );

    djb2_rewind #(.INIT(32'd5381), .MAXLEN(16'd2)) dut_b (
        .clock(clock), .resetn(resetn), .start(start), .target(target),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(rdy_b), .state(state_b), .count(count_b),
        .done(done_b), .match(match_b), .error(error_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
    endtask

    function automatic logic [31:0] djb2_fwd(input logic [31:0] s, input logic [7:0] b);
        return (s * 32'd33) ^ {24'b0, b};
    endfunction

    initial begin
        logic [7:0]  msg [8];
        logic [31:0] h;
        int          len;

        target = 32'h0;
        idle_inputs();
        resetn = 1'b0;
        #12;
        check("rst_state", state_a, 32'd5381);
        check("rst_count", {16'b0, count_a}, 32'd0);
        check("rst_ready", {31'b0, rdy_a}, 32'd0);
        check("rst_flags", {29'b0, done_a, match_a, error_a}, 32'd0);
        resetn = 1'b1;
        tick();

        // Single byte "a"
        start = 1'b1; target = 32'h0002B5C4;
        tick();
        start = 1'b0;
        check("load_state", state_a, 32'h0002B5C4);
        check("load_ready", {31'b0, rdy_a}, 32'd1);
        in_valid = 1'b1; in_data = 8'h61; in_last = 1'b1;
        tick();
        idle_inputs();
        check("a_state", state_a, 32'd5381);
        check("a_count", {16'b0, count_a}, 32'd1);
        check("a_flags", {29'b0, done_a, match_a, error_a}, 32'b110);
        check("a_ready_done", {31'b0, rdy_a}, 32'd0);
        tick();
        check("idle_flags", {29'b0, done_a, match_a, error_a}, 32'd0);
        check("idle_hold", state_a, 32'd5381);
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        check("idle_ignore", {count_a, 15'b0, rdy_a}, {16'd1, 16'd0});

        // "ab" rewound back-to-back: b then a
        start = 1'b1; target = 32'h00596E26;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h62; in_last = 1'b0;
        tick();
        check("ab_mid_state", state_a, 32'h0002B5C4);
        check("ab_mid_done", {31'b0, done_a}, 32'd0);
        in_data = 8'h61; in_last = 1'b1;
        tick();
        idle_inputs();
        check("ab_state", state_a, 32'd5381);
        check("ab_count", {16'b0, count_a}, 32'd2);
        check("ab_flags", {29'b0, done_a, match_a, error_a}, 32'b110);

        // Start while in DONE: pulse still seen, new job loads
        start = 1'b1; target = 32'h00596E26;
        tick();
        start = 1'b0;
        check("done_restart_state", state_a, 32'h00596E26);
        check("done_restart_ready", {31'b0, rdy_a}, 32'd1);

        // Wrong order: a then b
        in_valid = 1'b1; in_data = 8'h61; in_last = 1'b0;
        tick();
        in_data = 8'h62; in_last = 1'b1;
        tick();
        idle_inputs();
        check("wrong_flags", {29'b0, done_a, match_a, error_a}, 32'b100);
        check("wrong_count", {16'b0, count_a}, 32'd2);
        tick();

        // Abort mid-job with start; the byte offered alongside is dropped
        start = 1'b1; target = 32'h00596E26;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h62;
        tick();
        start = 1'b1; target = 32'h0002B5C4; in_data = 8'h62;
        tick();
        start = 1'b0;
        check("abort_state", state_a, 32'h0002B5C4);
        check("abort_count", {16'b0, count_a}, 32'd0);
        check("abort_nodone", {30'b0, done_a, rdy_a}, 32'b01);
        in_data = 8'h61; in_last = 1'b1;
        tick();
        idle_inputs();
        check("abort_flags", {29'b0, done_a, match_a, error_a}, 32'b110);
        check("abort_count2", {16'b0, count_a}, 32'd1);
        tick();
        check("abort_single", {31'b0, done_a}, 32'd0);

        // Overflow on the MAXLEN=2 instance
        start = 1'b1; target = 32'h12345678;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_last = 1'b0;
        in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        check("ovf_pre", {15'b0, done_b, count_b}, {16'd0, 16'd2});
        in_data = 8'h03; tick();
        in_valid = 1'b0;
        check("ovf_flags", {29'b0, done_b, match_b, error_b}, 32'b101);
        check("ovf_count", {16'b0, count_b}, 32'd2);
        check("big_no_ovf", {29'b0, done_a, match_a, error_a}, 32'd0);
        tick();
        check("ovf_after", {29'b0, done_b, match_b, error_b}, 32'd0);

        // Reset mid-job: dut_a is still in RUN
        #2 resetn = 1'b0;
        #1;
        check("midrst_state", state_a, 32'd5381);
        check("midrst_ready", {16'b0, count_a, 15'b0, rdy_a} , 32'd0);
        resetn = 1'b1;
        in_valid = 1'b1; in_data = 8'h61; in_last = 1'b1;
        tick();
        tick();
        idle_inputs();
        check("postrst_nojob", {count_a, 13'b0, done_a, rdy_a, error_a}, 32'd0);

        // Forward-hash random messages, then rewind them in reverse
        for (int t = 0; t < 6; t++) begin
            len = (t < 2) ? ((t == 0) ? 1 : 8) : $urandom_range(1, 8);
            h = 32'd5381;
            for (int i = 0; i < len; i++) begin
                msg[i] = 8'($urandom);
                h = djb2_fwd(h, msg[i]);
            end
            start = 1'b1; target = h;
            tick();
            start = 1'b0;
            for (int i = len - 1; i >= 0; i--) begin
                in_valid = 1'b1; in_data = msg[i]; in_last = (i == 0);
                tick();
            end
            idle_inputs();
            check("rt_flags", {29'b0, done_a, match_a, error_a}, 32'b110);
            check("rt_count", {16'b0, count_a}, len);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/djb2_rewind.md
DJB2_REWIND -- requirements
Module: djb2_rewind

Interface
REQ-001 Parameter INIT, default 32'd5381, DJB2 initial state to be recovered.
REQ-002 Parameter MAXLEN, default 16'd255, maximum bytes accepted per job.
REQ-003 clock  input  1  single clock; all state changes on posedge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  load target and begin a job; sampled every cycle.
REQ-006 target  input  32  final DJB2 hash value to rewind from.
REQ-007 in_valid  input  1  byte offered.
REQ-008 in_data  input  8  message byte, presented last-to-first.
REQ-009 in_last  input  1  marks the first message byte (final rewind step).
REQ-010 in_ready  output  1  block accepts a byte this cycle.
REQ-011 state  output  32  current rewound state.
REQ-012 count  output  16  bytes consumed in the current job.
REQ-013 done  output  1  one-cycle pulse at job end.
REQ-014 match  output  1  valid with done: rewound state equals INIT.
REQ-015 error  output  1  valid with done: job aborted on length overflow.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 In IDLE, start SHALL load state<=target and count<=0, and enter RUN next cycle.
REQ-018 in_ready SHALL be 1 only in RUN; bytes offered in IDLE or DONE are not consumed.
REQ-019 A byte SHALL be accepted when in_valid && in_ready.
REQ-020 Each accepted byte SHALL update state<=((state ^ {24'b0,in_data}) * 32'h3E0F83E1) mod 2^32 one cycle later (inverse of forward step s'=(s*33)^b), with count<=count+1.
REQ-021 Throughput SHALL be one byte per cycle; no bubbles while in_valid stays high.
REQ-022 Accepted byte with in_last=1 SHALL move the FSM to DONE on the same edge that updates state.
REQ-023 In DONE (exactly one cycle), done=1, match=(state==INIT), error=0; the FSM then returns to IDLE.
REQ-024 If a byte is accepted while count==MAXLEN, it SHALL NOT update state or count; FSM goes to DONE with match=0 and error=1.
REQ-025 start asserted in RUN SHALL abort the job: reload state<=target, count<=0, stay in RUN, no done pulse; any byte offered that cycle is discarded (in_ready remains 1 but start has priority).
REQ-026 start asserted in DONE SHALL be honoured as in IDLE (done pulse still emitted that cycle).
REQ-027 match and error SHALL be 0 whenever done=0.
REQ-028 state and count SHALL hold their values in IDLE until the next start.
REQ-029 Multiplication SHALL be truncated to 32 bits; no other arithmetic widens state.

Reset
REQ-030 resetn low SHALL immediately force FSM=IDLE, state=INIT, count=0, in_ready=0, done=0, match=0, error=0.
REQ-031 Reset asserted mid-job SHALL discard the job with no done pulse; first job after release requires start.

Verification
REQ-032 start, target=32'h0002B5C4; byte 8'h61 with in_last -> state=32'd5381, count=1, done=1, match=1, error=0.
REQ-033 start, target=32'h00596E26; bytes 8'h62 then 8'h61(in_last) back-to-back -> 2 cycles, state=5381, count=2, match=1.
REQ-034 Same target as REQ-033, bytes in forward order 8'h61, 8'h62(in_last) -> done=1, match=0, error=0.
REQ-035 MAXLEN=2: three bytes offered, none last -> third byte triggers done=1, error=1, match=0, count=2.
REQ-036 start mid-job with new target 32'h0002B5C4, then 8'h61(in_last) -> no done for aborted job; single done with match=1, count=1.
REQ-037 Formal: forward DJB2 over any free byte sequence of length 1..8 from INIT, then rewind in reverse order -> match=1 always (cover and assert).
